// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// UART transmitter, the companion of uart_rx. Each accepted request sends
// one frame on txd: a start bit (0), N_BITS data bits LSB first, and
// STOP_BITS stop bits (1). There is no parity. The baud timing comes from
// the same CLOCK_HZ / BAUD_RATE pair that uart_rx uses, so txd can be looped
// straight back into rxd.
//
// Parameters
//   BAUD_RATE  line bit rate in bit/s
//   CLOCK_HZ   clk frequency in Hz (CLOCK_HZ / BAUD_RATE must be >= 2)
//   STOP_BITS  stop bits per frame, 1 or 2
//   N_BITS     data bits per frame, 5..9
//
// Ports
//   clk       system clock, rising edge active
//   reset     asynchronous active-low reset (0 = reset)
//   enable    gates acceptance of new frames; a frame in flight always ends
//   start     transmit request, level-sampled while idle
//   data      word to send, captured when a frame is accepted
//   txd       serial line, registered, idles at 1
//   busy      1 while a frame is in flight
//   finished  one-cycle pulse after the last stop bit has completed
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int STOP_BITS = 1,
    parameter int N_BITS    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [N_BITS-1:0] data,
    output logic              txd,
    output logic              busy,
    output logic              finished
);

    localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int CNT_W     = $clog2(CLK_P_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_P_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(N_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [3:0]        bit_idx;
    logic [N_BITS-1:0] shift;
    logic              cell_done;

    // Every bit cell, stop cells included, lasts exactly CLK_P_BIT cycles.
    // The counter restarts at each cell boundary, so no error accumulates
    // over the frame.
    assign cell_done = (baud_cnt == CNT_LAST);

    // Frame sequencer. txd is loaded on the edge that enters each cell, so
    // the line changes only on clock edges and never glitches. bit_idx counts
    // data bits in DATA and stop cells in STOP. After STOP the FSM always
    // spends at least one cycle in IDLE, where finished is high. With start
    // held, the next frame is accepted on the edge that ends that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            finished <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (start && enable) begin
                        shift <= data;
                        state <= S_START;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cell_done) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cell_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            state   <= S_STOP;
                            txd     <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cell_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            bit_idx  <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx with two instances:
//   dut_a : 8 data bits, 1 stop bit, 10 clocks per bit (100-cycle frame)
//   dut_b : 7 data bits, 2 stop bits, 50 MHz / 115200 = 434 clocks per bit
// Both instances share clk, reset and enable.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int PA = 10;
    localparam int PB = 434;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start_a;
    logic [7:0] data_a;
    logic       txd_a;
    logic       busy_a;
    logic       finished_a;
    logic       start_b;
    logic [6:0] data_b;
    logic       txd_b;
    logic       busy_b;
    logic       finished_b;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .BAUD_RATE(100_000),
        .CLOCK_HZ (1_000_000),
        .STOP_BITS(1),
        .N_BITS   (8)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start_a),
        .data    (data_a),
        .txd     (txd_a),
        .busy    (busy_a),
        .finished(finished_a)
    );

    uart_tx #(
        .BAUD_RATE(115_200),
        .CLOCK_HZ (50_000_000),
        .STOP_BITS(2),
        .N_BITS   (7)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start_b),
        .data    (data_b),
        .txd     (txd_b),
        .busy    (busy_b),
        .finished(finished_b)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Raise start with the given word for one edge, then drop it.
    task automatic applyStimulus(input int sel, input logic [8:0] value);
        if (sel == 0) begin
            data_a  = value[7:0];
            start_a = 1'b1;
        end else begin
            data_b  = value[6:0];
            start_b = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Entered at the point right after the edge on which txd fell. Walks the
    // frame and checks the first and last cycle of every cell, then the one
    // IDLE cycle in which finished is high. Returns at that cycle.
    // disturb (dut_a only): 1 = new data and a start pulse mid-frame,
    //                       2 = enable dropped mid-frame.
    task automatic checkFrame(input int sel, input int p, input int nb, input int sb,
                              input logic [8:0] value, input int disturb, input string name);
        int   total;
        int   k;
        logic exp_txd;
        total = (1 + nb + sb) * p;
        for (int j = 0; j <= total; j++) begin
            if (j > 0) tick();
            k = j / p;
            if (k == 0)       exp_txd = 1'b0;
            else if (k <= nb) exp_txd = value[k-1];
            else              exp_txd = 1'b1;
            if ((j % p == 0) || (j % p == p - 1) || (j == total)) begin
                checkOutput($sformatf("%s txd@%0d", name, j),
                            {31'd0, (sel == 0) ? txd_a : txd_b}, {31'd0, exp_txd});
                checkOutput($sformatf("%s busy@%0d", name, j),
                            {31'd0, (sel == 0) ? busy_a : busy_b}, {31'd0, j < total});
                checkOutput($sformatf("%s finished@%0d", name, j),
                            {31'd0, (sel == 0) ? finished_a : finished_b}, {31'd0, j == total});
            end
            if (sel == 0 && disturb == 1 && j == 35) begin
                data_a  = 8'hAA;
                start_a = 1'b1;
            end
            if (sel == 0 && disturb == 1 && j == 36) start_a = 1'b0;
            if (sel == 0 && disturb == 2 && j == 35) enable = 1'b0;
        end
    endtask

    initial begin
        logic seen_busy;
        logic seen_fin;
        logic seen_low;

        reset   = 1'b0;
        enable  = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 7'h00;

        // Reset state.
        tick(2);
        checkOutput("reset txd",      {31'd0, txd_a},      32'd1);
        checkOutput("reset busy",     {31'd0, busy_a},     32'd0);
        checkOutput("reset finished", {31'd0, finished_a}, 32'd0);
        checkOutput("reset txd_b",    {31'd0, txd_b},      32'd1);
        reset = 1'b1;
        tick(3);
        checkOutput("idle txd", {31'd0, txd_a}, 32'd1);

        // Single frame of 'V' (0x56); txd must fall one edge after start.
        $display("[TB] frame 0x56");
        applyStimulus(0, 9'h056);
        checkFrame(0, PA, 8, 1, 9'h056, 0, "v56");
        tick();
        checkOutput("v56 finished single", {31'd0, finished_a}, 32'd0);
        checkOutput("v56 idle busy",       {31'd0, busy_a},     32'd0);

        // Back-to-back with start held: 0x00 then 0xFF. The second frame falls
        // on the edge after the finished cycle.
        $display("[TB] back-to-back 0x00 / 0xFF");
        tick(4);
        data_a  = 8'h00;
        start_a = 1'b1;
        tick();
        data_a = 8'hFF;
        checkFrame(0, PA, 8, 1, 9'h000, 0, "b2b0");
        tick();
        start_a = 1'b0;
        checkFrame(0, PA, 8, 1, 9'h0FF, 0, "b2b1");
        tick();
        checkOutput("b2b end busy", {31'd0, busy_a}, 32'd0);
        checkOutput("b2b end txd",  {31'd0, txd_a},  32'd1);

        // Mid-frame data change and start pulse are ignored.
        $display("[TB] mid-frame disturbance");
        tick(3);
        applyStimulus(0, 9'h03C);
        checkFrame(0, PA, 8, 1, 9'h03C, 1, "mid");
        tick();
        checkOutput("mid lost request busy", {31'd0, busy_a}, 32'd0);

        // start rises as enable falls: not accepted, then held off.
        $display("[TB] enable gating");
        tick(2);
        data_a  = 8'hA5;
        start_a = 1'b1;
        enable  = 1'b0;
        seen_busy = 1'b0;
        seen_low  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            seen_busy |= busy_a;
            seen_low  |= ~txd_a;
        end
        checkOutput("gated busy", {31'd0, seen_busy}, 32'd0);
        checkOutput("gated txd low", {31'd0, seen_low}, 32'd0);
        enable = 1'b1;
        tick();
        start_a = 1'b0;
        checkOutput("enable accept txd",  {31'd0, txd_a},  32'd0);
        checkOutput("enable accept busy", {31'd0, busy_a}, 32'd1);
        // enable drops during this frame; the frame still completes.
        checkFrame(0, PA, 8, 1, 9'h0A5, 2, "en");
        enable = 1'b1;
        tick(2);

        // Reset asserted during data bit 4 of 0x4A (bit 4 is 0).
        $display("[TB] reset mid-frame");
        applyStimulus(0, 9'h04A);
        tick(52);
        checkOutput("pre-reset txd", {31'd0, txd_a}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset txd",  {31'd0, txd_a},  32'd1);
        checkOutput("async reset busy", {31'd0, busy_a}, 32'd0);
        tick(3);
        reset = 1'b1;
        seen_fin  = 1'b0;
        seen_busy = 1'b0;
        seen_low  = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            seen_fin  |= finished_a;
            seen_busy |= busy_a;
            seen_low  |= ~txd_a;
        end
        checkOutput("post-reset finished", {31'd0, seen_fin},  32'd0);
        checkOutput("post-reset busy",     {31'd0, seen_busy}, 32'd0);
        checkOutput("post-reset txd low",  {31'd0, seen_low},  32'd0);
        applyStimulus(0, 9'h0C3);
        checkFrame(0, PA, 8, 1, 9'h0C3, 0, "rst");

        // Second configuration: 7 data bits, 2 stop bits, 434 clocks per bit.
        $display("[TB] 7N2 at 115200");
        tick(3);
        checkOutput("b idle txd", {31'd0, txd_b}, 32'd1);
        applyStimulus(1, 9'h035);
        checkFrame(1, PB, 7, 2, 9'h035, 0, "b35");
        tick();
        checkOutput("b end finished", {31'd0, finished_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
